pipe_stage_fifo: RTL and testbench
==================================

# pipe_stage_fifo

Parametrised elastic pipeline register for the RV32 core, generalising the fixed single-entry `en`/`flush` stage latches into a DEPTH-entry buffer with valid/ready handshakes on both sides. It carries an opaque packed bundle of stage fields (PC, control, operands, ALU result, branch prediction) of arbitrary width. It sits between any two pipeline stages, first between execute and memory. It lets a stalled downstream stage absorb in-flight instructions without a combinational ready path back through the pipe.

## Interface
- WIDTH, default 32: payload width in bits, 1 or more.
- DEPTH, default 2: number of entries, 1..16; need not be a power of two.
- CW, default $clog2(DEPTH+1): occupancy count width; derived, do not override.

- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  stage enable; 0 freezes the buffer (no push, no pop).
- flush  in  1  discard all entries (misprediction or exception); has priority over en, push and pop.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  buffer can accept an entry this cycle.
- in_data  in  WIDTH  payload from the upstream stage.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream consumes the head this cycle.
- out_data  out  WIDTH  head payload; all zeros when out_valid=0.
- count  out  CW  current occupancy, 0..DEPTH.

## Operation
- Storage: circular array mem[DEPTH], head pointer rd_ptr, tail pointer wr_ptr, and count register. Pointers advance by 1 and wrap from DEPTH-1 to 0 by explicit compare, with no modulo-2^n assumption.
- push = en & in_valid & in_ready & ~flush. A push writes mem[wr_ptr] and advances wr_ptr.
- pop = en & out_valid & out_ready & ~flush. A pop advances rd_ptr.
- Count update:
  - push only: count+1.
  - pop only: count−1.
  - push and pop together: count unchanged, and both pointers advance.
- in_ready = (count != DEPTH). It is decoded from registered count only and never depends on out_ready. When full, a simultaneous pop does not enable a push that same cycle.
- out_valid = (count != 0). out_data = mem[rd_ptr] when valid, else 0.
- A push while in_ready=0 is ignored, and upstream must hold in_data and in_valid. A pop while out_valid=0 is ignored.
- en=0 freezes pointers and count. in_ready and out_valid still reflect count.
- flush=1 sets rd_ptr, wr_ptr and count to 0 at the next edge. A same-cycle push is dropped and a same-cycle pop is not counted. Entry contents are not cleared.
- rst=1 has the same effect as flush and overrides every other input.
- Payload is opaque: no field interpretation and no bit reordering.

## Timing
- Reset values: count=0, out_valid=0, in_ready=1 (for DEPTH of 1 or more), out_data=0, rd_ptr=wr_ptr=0.
- Latency: an entry pushed at edge N is visible on out_valid and out_data after edge N, so it can be consumed in cycle N+1. There is no same-cycle bypass.
- Throughput:
  - DEPTH of 2 or more: one entry per cycle sustained while out_ready=1.
  - DEPTH=1: one entry per two cycles, because a full buffer blocks push even when a pop occurs.
- Flush: takes effect at the next edge. The cycle after a flush shows out_valid=0, count=0 and in_ready=1.
- Reset mid-operation: all in-flight entries are lost and outputs return to their reset values at the next edge.
- No combinational paths in_valid→out_valid, out_ready→in_ready or in_data→out_data. The only combinational outputs are the count decode and the mem[rd_ptr] read mux.

## Test plan
- Reset/idle: assert rst for 2 cycles with in_valid=1 and in_data=0xDEADBEEF. Required: count=0, out_valid=0, out_data=0 and in_ready=1 throughout and after release, and nothing is stored.
- Streaming, DEPTH=2, WIDTH=32, out_ready=1: push 0x1..0x8 on consecutive cycles. Required:
  - outputs 0x1..0x8 in order, each 1 cycle after its push;
  - count stays at 1;
  - in_ready never drops.
- Fill/backpressure, DEPTH=3: push 0xA, 0xB, 0xC with out_ready=0. Required:
  - count=3 and in_ready=0;
  - a further push of 0xD is ignored.
  - Then with out_ready=1 and in_valid=0, out_data reads 0xA, 0xB, 0xC and count steps 3→2→1→0.
- Wrap-around, DEPTH=3 (non-power-of-two): 20 push/pop cycles with random out_ready and in_valid. Required: output order matches a scoreboard, count never exceeds 3, and pointers wrap 2→0.
- Flush priority: with DEPTH=2 full (0x11, 0x22), assert flush together with in_valid=1 (0x33) and out_ready=1. Required: next cycle count=0, out_valid=0, and 0x33 never appears.
- Freeze: with count=1 (0x55), drive en=0, in_valid=1 (0x66) and out_ready=1 for 3 cycles. Required: count remains 1 and out_data remains 0x55. On en=1, 0x55 is popped and 0x66 is pushed in the same cycle.

Source files
------------

// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline register: DEPTH-entry circular buffer with valid/ready on both sides.
// in_ready and out_valid decode only the registered count, so no ready path runs back through the stage.
module pipe_stage_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             push;
    logic             pop;

    // Pointers wrap by explicit compare so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign push      = en & in_valid & in_ready & ~flush & ~rst;
    assign pop       = en & out_valid & out_ready & ~flush & ~rst;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end
endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed bench for pipe_stage_fifo: a DEPTH=2 and a DEPTH=3 instance, each checked
// every cycle against a queue scoreboard of expected contents.
module tb_pipe_stage_fifo;
    logic        clk;
    logic        rst;
    logic        en2, fl2, iv2, ir2, ov2, or2;
    logic [31:0] id2, od2;
    logic [1:0]  cnt2;
    logic        en3, fl3, iv3, ir3, ov3, or3;
    logic [31:0] id3, od3;
    logic [1:0]  cnt3;

    logic [31:0] q2[$];
    logic [31:0] q3[$];
    bit          pushed2, pushed3;
    int          vectors = 0;
    int          miscompares = 0;

    pipe_stage_fifo #(.WIDTH(32), .DEPTH(2)) u2 (
        .clk(clk), .rst(rst), .en(en2), .flush(fl2),
        .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .count(cnt2)
    );

    pipe_stage_fifo #(.WIDTH(32), .DEPTH(3)) u3 (
        .clk(clk), .rst(rst), .en(en3), .flush(fl3),
        .in_valid(iv3), .in_ready(ir3), .in_data(id3),
        .out_valid(ov3), .out_ready(or3), .out_data(od3), .count(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks one instance against its scoreboard, then advances the scoreboard to the post-edge state.
    task automatic side(input string n, input int depth, input logic e, input logic fl,
                        input logic iv, input logic orr, input logic ir, input logic ov,
                        input logic [31:0] od, input logic [31:0] cnt, input logic [31:0] din,
                        inout logic [31:0] q[$], output bit pushed);
        int sz;
        bit pp;
        bit pu;
        sz = q.size();
        chk({n, "_count"}, cnt, 32'(sz));
        chk({n, "_in_ready"}, 32'(ir), 32'(sz != depth));
        chk({n, "_out_valid"}, 32'(ov), 32'(sz != 0));
        pp = !rst && e && !fl && orr && (sz != 0);
        pu = !rst && e && !fl && iv && (sz != depth);
        if (sz == 0)  chk({n, "_idle_data"}, od, 32'h0);
        else if (pp)  chk({n, "_pop_data"}, od, q.pop_front());
        else          chk({n, "_head_data"}, od, q[0]);
        if (rst || fl) q.delete();
        else if (pu)   q.push_back(din);
        pushed = pu;
    endtask

    task automatic step();
        side("d2", 2, en2, fl2, iv2, or2, ir2, ov2, od2, 32'(cnt2), id2, q2, pushed2);
        side("d3", 3, en3, fl3, iv3, or3, ir3, ov3, od3, 32'(cnt3), id3, q3, pushed3);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        en2 = 1'b1; fl2 = 1'b0; iv2 = 1'b1; id2 = 32'hDEADBEEF; or2 = 1'b0;
        en3 = 1'b1; fl3 = 1'b0; iv3 = 1'b1; id3 = 32'hDEADBEEF; or3 = 1'b0;

        // Reset with a pending offer: nothing may be stored.
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        iv2 = 1'b0; iv3 = 1'b0;
        step();
        step();

        // Streaming through DEPTH=2 with out_ready held high.
        or2 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            iv2 = 1'b1;
            id2 = 32'(i);
            step();
            if (i > 1) chk("stream_count", 32'(cnt2), 32'd1);
        end
        iv2 = 1'b0;
        step();
        step();

        // Fill DEPTH=3, then offer one more while full.
        or3 = 1'b0;
        iv3 = 1'b1;
        id3 = 32'hA; step();
        id3 = 32'hB; step();
        id3 = 32'hC; step();
        chk("fill_count", 32'(cnt3), 32'd3);
        chk("fill_in_ready", 32'(ir3), 32'd0);
        id3 = 32'hD; step();
        iv3 = 1'b0;
        or3 = 1'b1;
        repeat (4) step();

        // Random traffic on DEPTH=3 so both pointers wrap several times.
        for (int i = 0; i < 20; i++) begin
            if (!iv3 || pushed3) begin
                iv3 = 1'($urandom_range(0, 1));
                id3 = 32'h100 + 32'(i);
            end
            or3 = 1'($urandom_range(0, 1));
            step();
        end
        iv3 = 1'b0;
        or3 = 1'b1;
        repeat (4) step();
        or3 = 1'b0;

        // Flush beats a simultaneous push and pop.
        or2 = 1'b0;
        iv2 = 1'b1;
        id2 = 32'h11; step();
        id2 = 32'h22; step();
        fl2 = 1'b1;
        id2 = 32'h33;
        or2 = 1'b1;
        step();
        fl2 = 1'b0;
        iv2 = 1'b0;
        chk("flush_count", 32'(cnt2), 32'd0);
        chk("flush_out_valid", 32'(ov2), 32'd0);
        chk("flush_in_ready", 32'(ir2), 32'd1);
        step();
        step();

        // Freeze with one entry, then release into a same-cycle pop and push.
        or2 = 1'b0;
        iv2 = 1'b1;
        id2 = 32'h55;
        step();
        en2 = 1'b0;
        id2 = 32'h66;
        or2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("freeze_data", od2, 32'h55);
        end
        en2 = 1'b1;
        step();
        chk("release_data", od2, 32'h66);
        chk("release_count", 32'(cnt2), 32'd1);
        iv2 = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
